mem_responder_np: RTL

Parametrised N-port word memory slave with a req/ack handshake and configurable response latency, replacing the tie-off pattern where ack equals req and read data is combinational. It sits in the processor benches between the core's instruction and data ports and a shared word array. It lets the core be exercised against delayed acknowledgements and multi-cycle memory, and reduces to the legacy zero-latency behaviour when LATENCY=0.

---
 rtl/mem_responder_np_if.sv | 24 ++
 rtl/mem_responder_np.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_responder_np_if.sv
// Bundle of per-port req/ack memory signals shared by the memory responder
// and whatever master drives it (core ports or a bench).
interface mem_responder_np_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                 req_i;
  logic [NUM_PORTS-1:0]                 we_i;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;
  logic [NUM_PORTS-1:0]                 ack_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o
  );
endinterface

// File: rtl/mem_responder_np.sv
// N-port word memory slave with req/ack handshake and configurable response
// latency. LATENCY=0 gives the legacy combinational tie-off (ack = req, read
// data straight from the array); LATENCY>=1 runs an IDLE/WAIT/ACK FSM per
// port with registered ack and read data.
module mem_responder_np #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int NUM_PORTS  = 2,
  parameter int LATENCY    = 1
) (
  input logic               clk_i,
  input logic               arst_ni,
  mem_responder_np_if.slave bus
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  typedef logic [IDX_W-1:0] idx_t;

  // Byte address -> word index; byte-offset bits dropped, upper bits wrap.
  function automatic idx_t word_idx(input logic [ADDR_WIDTH-1:0] a);
    return idx_t'(a >> OFF_W);
  endfunction

  // Word array; deliberately never reset so contents survive arst_ni.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  if (LATENCY == 0) begin : g_legacy
    // Reset has no effect in the zero-latency tie-off.
    logic unused_rst;
    assign unused_rst = arst_ni;

    assign bus.ack_o = bus.req_i;
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
      assign bus.rdata_o[p] = mem_q[word_idx(bus.addr_i[p])];
    end

    // Write on every edge with req&we; descending loop lets port 0 win.
    always_ff @(posedge clk_i) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (bus.req_i[p] && bus.we_i[p]) begin
          mem_q[word_idx(bus.addr_i[p])] <= bus.wdata_i[p];
        end
      end
    end
  end else begin : g_fsm
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                               state_q [NUM_PORTS];
    state_t                               state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]                 accept;
    logic [NUM_PORTS-1:0]                 rd_load;
    idx_t                                 rd_idx  [NUM_PORTS];
    logic [NUM_PORTS-1:0]                 we_q;
    idx_t                                 idx_q   [NUM_PORTS];
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;

    // Per-port next state, counter, capture strobe and read-data load.
    // With LATENCY=1 the FSM enters ACK straight from IDLE, so the read
    // index must come from the live address rather than the capture regs.
    always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_d[p] = state_q[p];
        cnt_d[p]   = cnt_q[p];
        accept[p]  = 1'b0;
        rd_load[p] = 1'b0;
        rd_idx[p]  = idx_q[p];
        case (state_q[p])
          IDLE: begin
            rd_idx[p] = word_idx(bus.addr_i[p]);
            if (bus.req_i[p]) begin
              accept[p] = 1'b1;
              cnt_d[p]  = CNT_W'(LATENCY - 1);
              if (LATENCY == 1) begin
                state_d[p] = ACK;
                rd_load[p] = ~bus.we_i[p];
              end else begin
                state_d[p] = WAIT;
              end
            end
          end
          WAIT: begin
            cnt_d[p] = cnt_q[p] - CNT_W'(1);
            if (cnt_q[p] == CNT_W'(1)) begin
              state_d[p] = ACK;
              rd_load[p] = ~we_q[p];
            end
          end
          ACK:     state_d[p] = IDLE;
          default: state_d[p] = IDLE;
        endcase
      end
    end

    // Control state and read-data registers; reset aborts any transaction.
    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          state_q[p] <= IDLE;
          cnt_q[p]   <= '0;
          rdata_q[p] <= '0;
        end
      end else begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          state_q[p] <= state_d[p];
          cnt_q[p]   <= cnt_d[p];
          if (rd_load[p]) begin
            rdata_q[p] <= mem_q[rd_idx[p]];
          end
        end
      end
    end

    // Capture the request fields at acceptance; later input changes ignored.
    always_ff @(posedge clk_i) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p]) begin
          we_q[p]    <= bus.we_i[p];
          idx_q[p]   <= word_idx(bus.addr_i[p]);
          wdata_q[p] <= bus.wdata_i[p];
        end
      end
    end

    // Commit writes at the edge ending ACK; descending loop lets port 0 win.
    always_ff @(posedge clk_i) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (state_q[p] == ACK && we_q[p]) begin
          mem_q[idx_q[p]] <= wdata_q[p];
        end
      end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
      assign bus.ack_o[p] = (state_q[p] == ACK);
    end
    assign bus.rdata_o = rdata_q;
  end

endmodule
